// File: rtl/mem_search_ctrl.sv
// Search controller: follows a hit-driven address chain through a search memory
// and reports the last matching address and the number of consecutive hits.
module mem_search_ctrl #(
   parameter int D          = 8,
   parameter int A          = 8,   // must be 8: the external shift stage is 8 bits wide
   parameter int START_ADDR = 0,
   parameter int MAX_STEPS  = 8    // 1..15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [D-1:0] key,
   output logic         mem_rd,
   output logic [A-1:0] mem_addr,
   input  logic [D-1:0] mem_rdata,
   output logic [A-1:0] shift_addr,
   output logic         shift_hit,
   input  logic [A-1:0] shift_next,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic [A-1:0] result_addr,
   output logic [3:0]   depth
);

   typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

   localparam logic [A-1:0] START = A'(START_ADDR);
   localparam logic [3:0]   LIMIT = 4'(MAX_STEPS);

   state_t       state;
   logic [D-1:0] key_q;
   logic [A-1:0] addr_q;
   logic         hit;

   // Read data is only meaningful in CMP, so the hit flag is gated by state.
   assign hit        = (state == CMP) && (mem_rdata == key_q);
   assign shift_addr = addr_q;
   assign shift_hit  = hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         key_q       <= '0;
         addr_q      <= '0;
         mem_rd      <= 1'b0;
         mem_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         result_addr <= '0;
         depth       <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_rd <= 1'b0;
               done   <= 1'b0;
               if (start) begin
                  key_q       <= key;
                  addr_q      <= START;
                  depth       <= '0;
                  found       <= 1'b0;
                  result_addr <= '0;
                  busy        <= 1'b1;
                  mem_rd      <= 1'b1;
                  mem_addr    <= START;
                  state       <= READ;
               end
            end
            READ: begin
               mem_rd <= 1'b0;
               state  <= CMP;
            end
            CMP: begin
               if (hit) begin
                  result_addr <= addr_q;
                  depth       <= depth + 4'd1;
                  found       <= 1'b1;
                  addr_q      <= shift_next;
                  if (depth + 4'd1 == LIMIT) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     // Strobe the next read so it is valid during the coming READ cycle.
                     mem_rd   <= 1'b1;
                     mem_addr <= shift_next;
                     state    <= READ;
                  end
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_search_ctrl.sv
// Bench for mem_search_ctrl: a behavioural memory and shift stage, plus a chain-walk
// reference model that predicts reads, hits, latency and the final result.
module tb_mem_search_ctrl;

   localparam int MAX_STEPS = 8;
   localparam logic [7:0] START = 8'd0;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] key;
   logic       mem_rd;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] shift_addr;
   logic       shift_hit;
   logic [7:0] shift_next;
   logic       busy;
   logic       done;
   logic       found;
   logic [7:0] result_addr;
   logic [3:0] depth;

   logic [7:0] mem [256];
   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] exp_q[$];
   logic       exp_hit_q[$];
   int         exp_depth;
   logic       exp_found;
   logic [7:0] exp_res;

   mem_search_ctrl #(.D(8), .A(8), .START_ADDR(0), .MAX_STEPS(MAX_STEPS)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .shift_addr(shift_addr), .shift_hit(shift_hit), .shift_next(shift_next),
      .busy(busy), .done(done), .found(found), .result_addr(result_addr), .depth(depth)
   );

   always #5 clk = ~clk;

   // Synchronous memory: data appears the cycle after the read strobe.
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

   // Downstream shift stage.
   assign shift_next = shift_hit ? {shift_addr[6:0], 1'b1} : 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walk the chain: next address is 2*a+1 (8-bit), stop on miss or after MAX_STEPS hits.
   task automatic build_model(input logic [7:0] k);
      logic [7:0] a;
      a = START;
      exp_q.delete();
      exp_hit_q.delete();
      exp_depth = 0;
      exp_found = 1'b0;
      exp_res   = 8'h00;
      for (int s = 0; s < 16; s++) begin
         exp_q.push_back(a);
         if (mem[a] == k) begin
            exp_hit_q.push_back(1'b1);
            exp_depth++;
            exp_found = 1'b1;
            exp_res   = a;
            if (exp_depth == MAX_STEPS) break;
            a = 8'((2 * int'(a)) + 1);
         end else begin
            exp_hit_q.push_back(1'b0);
            break;
         end
      end
   endtask

   // Entered at the negedge of an IDLE cycle; leaves at the negedge of the IDLE cycle after DONE.
   task automatic run_search(input logic [7:0] k, input bit hold, input bit poke);
      logic [7:0] obs_rd[$];
      logic       obs_hit[$];
      int         done_cycle;
      logic       prev_rd;
      build_model(k);
      key   = k;
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      done_cycle = -1;
      prev_rd    = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         key = 8'($urandom);
         if (poke && c == 3) start = 1'b1;
         if (poke && c == 4) start = 1'b0;
         if (prev_rd) begin
            check("shift_addr", shift_addr, obs_rd[$]);
            obs_hit.push_back(shift_hit);
         end else begin
            check("hit_outside_cmp", shift_hit, 0);
         end
         prev_rd = mem_rd;
         if (mem_rd) obs_rd.push_back(mem_addr);
         check("rd_quiet", mem_rd & (done | ~busy), 0);
         if (done) begin
            done_cycle = c;
            check("done_busy", busy, 1);
            break;
         end
      end
      check("latency", done_cycle, 2 * exp_q.size() + 1);
      check("n_reads", obs_rd.size(), exp_q.size());
      for (int i = 0; i < obs_rd.size() && i < exp_q.size(); i++)
         check("rd_addr", obs_rd[i], exp_q[i]);
      check("n_hits", obs_hit.size(), exp_hit_q.size());
      for (int i = 0; i < obs_hit.size() && i < exp_hit_q.size(); i++)
         check("hit_seq", obs_hit[i], exp_hit_q[i]);
      check("found", found, exp_found);
      check("result_addr", result_addr, exp_res);
      check("depth", depth, exp_depth);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_rd", mem_rd, 0);
      check("hold_found", found, exp_found);
      check("hold_result", result_addr, exp_res);
      check("hold_depth", depth, exp_depth);
      if (!hold) begin
         repeat (3) begin
            @(negedge clk);
            check("quiet_done", done, 0);
            check("quiet_busy", busy, 0);
         end
      end
   endtask

   task automatic fill_mem(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic fill_random(input logic [7:0] k);
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 4) != 0) ? k : 8'($urandom);
   endtask

   initial begin
      logic [7:0] k;
      rst   = 1'b1;
      start = 1'b0;
      key   = 8'h00;
      fill_mem(8'h00);
      repeat (3) @(negedge clk);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_found", found, 0);
      check("rst_result", result_addr, 0);
      check("rst_depth", depth, 0);
      check("rst_shift_addr", shift_addr, 0);
      check("rst_shift_hit", shift_hit, 0);
      rst = 1'b0;
      @(negedge clk);

      // Chain hit then miss: reads 0,1,3,7.
      fill_mem(8'h00);
      mem[0] = 8'hAA; mem[1] = 8'hAA; mem[3] = 8'hAA; mem[7] = 8'h55;
      run_search(8'hAA, 1'b0, 1'b0);
      check("plan_chain_depth", depth, 3);
      check("plan_chain_result", result_addr, 3);

      // Immediate miss.
      fill_mem(8'h00);
      mem[0] = 8'h12;
      run_search(8'h34, 1'b0, 1'b0);
      check("plan_miss_found", found, 0);

      // Step limit.
      fill_mem(8'hFF);
      run_search(8'hFF, 1'b0, 1'b0);
      check("plan_limit_depth", depth, 8);
      check("plan_limit_result", result_addr, 127);

      // Start pulsed during the second READ with a different key.
      fill_mem(8'h00);
      mem[0] = 8'h5A; mem[1] = 8'h5A; mem[3] = 8'h5A; mem[7] = 8'h11;
      run_search(8'h5A, 1'b0, 1'b1);

      // Reset during CMP of step 2.
      fill_mem(8'h00);
      mem[0] = 8'h3C; mem[1] = 8'h3C; mem[3] = 8'h3C;
      key   = 8'h3C;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_found", found, 1);
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("arst_mem_rd", mem_rd, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_found", found, 0);
      check("arst_depth", depth, 0);
      check("arst_result", result_addr, 0);
      check("arst_shift_hit", shift_hit, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_done", done, 0);
         check("post_rst_busy", busy, 0);
      end
      run_search(8'h3C, 1'b0, 1'b0);

      // Back-to-back with start held high.
      for (int t = 0; t < 4; t++) begin
         k = 8'($urandom);
         fill_random(k);
         run_search(k, 1'b1, 1'b0);
      end
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Random searches.
      for (int t = 0; t < 20; t++) begin
         k = 8'($urandom);
         fill_random(k);
         run_search(k, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_search_ctrl.md
Name: mem_search_ctrl

Overview:
- Sequential controller that walks a search memory along a match-driven address chain.
- Reads the word at the current address and compares it with a latched key.
- Hands the current address and the hit flag to the downstream shift-address stage. That stage returns {addr[6:0],1} on a hit and 0 on a miss.
- Loads the returned next address and repeats until a miss or the step limit, then reports the result.

Parameters:
- D, 8, data width of the key and of memory words.
- A, 8, address width. The downstream shift stage is 8 bits wide, so A must equal 8.
- START_ADDR, 0, first address read after start.
- MAX_STEPS, 8, maximum consecutive hits before forced termination (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a new search. Sampled in IDLE only.
- key  in  D  search key. Latched on an accepted start.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  A  memory read address.
- mem_rdata  in  D  memory read data. Valid exactly 1 cycle after mem_rd.
- shift_addr  out  A  current address, to the shift stage input a.
- shift_hit  out  1  compare hit, to the shift stage input b.
- shift_next  in  A  next address, from the shift stage output c.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle completion pulse.
- found  out  1  at least one hit in the last search.
- result_addr  out  A  address of the last hit.
- depth  out  4  number of hits in the last search.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - mem_rd=0, mem_addr=0, busy=0, done=0, found=0, result_addr=0, depth=0.
  - Internal address and key registers = 0.
  - A search in progress is abandoned; no done pulse follows reset.
- States: IDLE, READ, CMP, DONE.
- IDLE:
  - When start=1: key_q<=key, addr_q<=START_ADDR, depth<=0, found<=0, result_addr<=0, busy<=1, go to READ.
  - Otherwise stay in IDLE.
- READ (one cycle):
  - mem_rd=1 and mem_addr=addr_q, both registered so they are high/valid during this cycle.
  - Go to CMP.
- CMP (one cycle):
  - mem_rdata is valid in this cycle.
  - hit = (mem_rdata==key_q).
  - shift_addr=addr_q and shift_hit=hit, driven combinationally; shift_next is consumed in the same cycle.
  - On hit:
    - result_addr<=addr_q, depth<=depth+1, found<=1, addr_q<=shift_next.
    - If depth+1==MAX_STEPS, go to DONE; else go to READ.
  - On miss: go to DONE. addr_q is unchanged; the shift stage returns 0 and that value is ignored.
- DONE (one cycle):
  - done=1, busy=0 on exit, go to IDLE.
  - found, result_addr and depth hold until the next accepted start or reset.
- Outside CMP: shift_hit=0; shift_addr follows addr_q.
- mem_rd=0 in every state except READ. mem_addr holds its last value.
- start while busy (READ/CMP/DONE) is ignored and not queued.
- start asserted during the DONE cycle is ignored. The earliest new start is accepted in the IDLE cycle after DONE.
- key changes while busy have no effect, because key_q is used.
- Latency: with N reads (N = hits + 1 on a miss, or N = MAX_STEPS on the limit), done is high 2N+1 cycles after the cycle in which start was accepted.
- Address saturation: address 0xFF on a hit returns 0xFF. The loop is bounded by MAX_STEPS.
- depth arithmetic is 4-bit unsigned. It cannot wrap, since MAX_STEPS≤15.

Test Plan:
- Chain hit then miss: mem[0]=mem[1]=mem[3]=0xAA, mem[7]=0x55, key=0xAA, START_ADDR=0 -> reads 0,1,3,7; shift_hit 1,1,1,0; done 9 cycles after start; found=1, result_addr=3, depth=3.
- Immediate miss: mem[0]=0x12, key=0x34 -> single read of address 0; done after 3 cycles; found=0, depth=0, result_addr=0.
- Step limit: all memory=0xFF, key=0xFF, MAX_STEPS=8 -> reads 0,1,3,7,15,31,63,127; done after 17 cycles; depth=8, result_addr=127, found=1.
- Start while busy: pulse start again during the 2nd READ with a different key -> ignored; the result matches the first search only; exactly one done pulse.
- Reset mid-search: assert rst asynchronously during CMP of step 2 -> mem_rd, busy, done, found, depth, result_addr all 0 immediately; no done pulse; a new start after release runs normally from START_ADDR.
- Back-to-back: start held high continuously -> a new search is accepted in the IDLE cycle after each DONE; mem_rd is never high in IDLE or DONE.
